// File: rtl/fei4_rx_record_packer.sv
// Packs decoded FEI4 link bytes into 24-bit records framed by SOF/EOF K-characters,
// buffers one completed word for the downstream FIFO and counts drops and framing errors.
module fei4_rx_record_packer #(
    parameter logic [7:0] CHANNEL_ID = 8'h00,
    parameter logic [7:0] K_SOF      = 8'hFC,
    parameter logic [7:0] K_EOF      = 8'hBC,
    parameter logic [7:0] K_IDLE     = 8'h3C
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  byte_in,
    input  logic        byte_valid,
    input  logic        is_k,
    input  logic        dec_err,
    input  logic        cnt_clear,
    input  logic        fifo_full,
    output logic        fifo_write,
    output logic [31:0] fifo_data,
    output logic        frame_active,
    output logic [15:0] lost_count,
    output logic [7:0]  err_count
);

    typedef enum logic {IDLE, FRAME} state_t;

    state_t      state, state_n;
    logic [1:0]  cnt, cnt_n;
    logic [15:0] partial, partial_n;
    logic        hold_valid, hold_valid_n;
    logic [31:0] hold_data, hold_data_n;
    logic [15:0] lost_n;
    logic [7:0]  err_n;
    logic        err_event, lost_event, complete;

    // Gated by reset so a pending word can never leak out while reset is held.
    assign fifo_write   = hold_valid & ~fifo_full & reset;
    assign fifo_data    = hold_data;
    assign frame_active = (state == FRAME);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE;
            cnt        <= 2'd0;
            partial    <= 16'd0;
            hold_valid <= 1'b0;
            hold_data  <= 32'd0;
            lost_count <= 16'd0;
            err_count  <= 8'd0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            partial    <= partial_n;
            hold_valid <= hold_valid_n;
            hold_data  <= hold_data_n;
            lost_count <= lost_n;
            err_count  <= err_n;
        end
    end

    always_comb begin
        state_n      = state;
        cnt_n        = cnt;
        partial_n    = partial;
        hold_valid_n = hold_valid;
        hold_data_n  = hold_data;
        lost_n       = lost_count;
        err_n        = err_count;
        err_event    = 1'b0;
        lost_event   = 1'b0;
        complete     = 1'b0;

        // A decoder error outranks every interpretation of the byte itself.
        if (byte_valid) begin
            if (dec_err) begin
                state_n   = IDLE;
                cnt_n     = 2'd0;
                err_event = 1'b1;
            end else if (state == IDLE) begin
                if (is_k && byte_in == K_SOF) begin
                    state_n = FRAME;
                    cnt_n   = 2'd0;
                end
            end else if (!is_k) begin
                if (cnt == 2'd2) begin
                    complete = 1'b1;
                    cnt_n    = 2'd0;
                end else begin
                    cnt_n     = cnt + 2'd1;
                    partial_n = {partial[7:0], byte_in};
                end
            end else if (byte_in == K_EOF) begin
                state_n   = IDLE;
                cnt_n     = 2'd0;
                err_event = (cnt != 2'd0);
            end else if (byte_in == K_SOF) begin
                cnt_n     = 2'd0;
                err_event = (cnt != 2'd0);
            end else if (byte_in != K_IDLE) begin
                state_n   = IDLE;
                cnt_n     = 2'd0;
                err_event = 1'b1;
            end
        end

        // The holding register accepts a new record in the same cycle it drains.
        if (complete) begin
            if (!hold_valid || fifo_write) begin
                hold_valid_n = 1'b1;
                hold_data_n  = {CHANNEL_ID, partial, byte_in};
            end else begin
                lost_event = 1'b1;
            end
        end else if (fifo_write) begin
            hold_valid_n = 1'b0;
        end

        if (cnt_clear) begin
            lost_n = 16'd0;
            err_n  = 8'd0;
        end else begin
            if (lost_event && lost_count != 16'hFFFF)
                lost_n = lost_count + 16'd1;
            if (err_event && err_count != 8'hFF)
                err_n = err_count + 8'd1;
        end
    end

endmodule

// File: tb/tb_fei4_rx_record_packer.sv
// Table-driven bench for fei4_rx_record_packer; written words are checked against a
// scoreboard queue filled when the completing byte is driven.
module tb_fei4_rx_record_packer;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  byte_in;
    logic        byte_valid, is_k, dec_err, cnt_clear, fifo_full;
    logic        fifo_write;
    logic [31:0] fifo_data;
    logic        frame_active;
    logic [15:0] lost_count;
    logic [7:0]  err_count;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic        rst_n, valid, k, derr, full, clr;
        logic [7:0]  b;
        logic        exp_write, exp_active;
        logic [7:0]  exp_err;
        logic [15:0] exp_lost;
        logic        chk_data, push;
        logic [31:0] word;
    } vec_t;

    vec_t        vecs[$];
    logic [31:0] sbq[$];

    fei4_rx_record_packer #(.CHANNEL_ID(8'h05)) dut (
        .clk(clk), .reset(reset), .byte_in(byte_in), .byte_valid(byte_valid),
        .is_k(is_k), .dec_err(dec_err), .cnt_clear(cnt_clear), .fifo_full(fifo_full),
        .fifo_write(fifo_write), .fifo_data(fifo_data), .frame_active(frame_active),
        .lost_count(lost_count), .err_count(err_count)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic rst_n, valid, k, derr, input logic [7:0] b,
                                input logic full, clr, ew, ea, input logic [7:0] ee,
                                input logic [15:0] el, input logic chk, push,
                                input logic [31:0] word);
        vec_t v;
        v.rst_n = rst_n; v.valid = valid; v.k = k; v.derr = derr; v.b = b;
        v.full = full; v.clr = clr; v.exp_write = ew; v.exp_active = ea;
        v.exp_err = ee; v.exp_lost = el; v.chk_data = chk; v.push = push; v.word = word;
        return v;
    endfunction

    task automatic add(input logic rst_n, valid, k, derr, input logic [7:0] b,
                       input logic full, clr, ew, ea, input logic [7:0] ee,
                       input logic [15:0] el, input logic chk, push, input logic [31:0] word);
        vecs.push_back(mk(rst_n, valid, k, derr, b, full, clr, ew, ea, ee, el, chk, push, word));
    endtask

    task automatic compare(input string name, input int idx, input logic [31:0] act,
                           input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s vec %0d: got %h expected %h", name, idx, act, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        reset      = v.rst_n;
        byte_valid = v.valid;
        is_k       = v.k;
        dec_err    = v.derr;
        byte_in    = v.b;
        fifo_full  = v.full;
        cnt_clear  = v.clr;
        if (v.push) sbq.push_back(v.word);
    endtask

    task automatic checkOutput(input vec_t v, input int idx);
        compare("fifo_write", idx, {31'd0, fifo_write}, {31'd0, v.exp_write});
        compare("frame_active", idx, {31'd0, frame_active}, {31'd0, v.exp_active});
        compare("err_count", idx, {24'd0, err_count}, {24'd0, v.exp_err});
        compare("lost_count", idx, {16'd0, lost_count}, {16'd0, v.exp_lost});
        if (v.chk_data) compare("fifo_data_hold", idx, fifo_data, v.word);
        if (fifo_write === 1'b1) begin
            if (sbq.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL sb_unexpected vec %0d: got write of %h expected no write",
                         idx, fifo_data);
            end else begin
                compare("sb_data", idx, fifo_data, sbq.pop_front());
            end
        end
    endtask

    // Inputs change 1 ns after the rising edge; outputs are sampled on the falling edge.
    task automatic runVec(input vec_t v, input int idx);
        applyStimulus(v);
        @(negedge clk);
        checkOutput(v, idx);
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b0; byte_in = 8'h00; byte_valid = 1'b0; is_k = 1'b0;
        dec_err = 1'b0; cnt_clear = 1'b0; fifo_full = 1'b0;

        //   rst v k e byte  f c  ew ea err   lost  chk push word
        add(0, 1, 1, 0, 8'hFC, 0, 0, 0, 0, 8'd0, 16'd0, 1, 0, 32'h0);
        add(1, 1, 1, 0, 8'hFC, 0, 0, 0, 0, 8'd0, 16'd0, 0, 0, 32'h0);
        add(1, 1, 0, 0, 8'hAB, 0, 0, 0, 1, 8'd0, 16'd0, 0, 0, 32'h0);
        add(1, 1, 0, 0, 8'hCD, 0, 0, 0, 1, 8'd0, 16'd0, 0, 0, 32'h0);
        add(1, 1, 0, 0, 8'hEF, 0, 0, 0, 1, 8'd0, 16'd0, 0, 1, 32'h05ABCDEF);
        add(1, 1, 1, 0, 8'hBC, 0, 0, 1, 1, 8'd0, 16'd0, 1, 0, 32'h05ABCDEF);
        add(1, 0, 0, 0, 8'h00, 0, 0, 0, 0, 8'd0, 16'd0, 0, 0, 32'h0);
        // Short frame: EOF after two data bytes
        add(1, 1, 1, 0, 8'hFC, 0, 0, 0, 0, 8'd0, 16'd0, 0, 0, 32'h0);
        add(1, 1, 0, 0, 8'h11, 0, 0, 0, 1, 8'd0, 16'd0, 0, 0, 32'h0);
        add(1, 1, 0, 0, 8'h22, 0, 0, 0, 1, 8'd0, 16'd0, 0, 0, 32'h0);
        add(1, 1, 1, 0, 8'hBC, 0, 0, 0, 1, 8'd0, 16'd0, 0, 0, 32'h0);
        add(1, 0, 0, 0, 8'h00, 0, 0, 0, 0, 8'd1, 16'd0, 0, 0, 32'h0);
        // Decoder error in frame, following data ignored
        add(1, 1, 1, 0, 8'hFC, 0, 0, 0, 0, 8'd1, 16'd0, 0, 0, 32'h0);
        add(1, 1, 0, 0, 8'h33, 0, 0, 0, 1, 8'd1, 16'd0, 0, 0, 32'h0);
        add(1, 1, 0, 1, 8'h44, 0, 0, 0, 1, 8'd1, 16'd0, 0, 0, 32'h0);
        add(1, 1, 0, 0, 8'h55, 0, 0, 0, 0, 8'd2, 16'd0, 0, 0, 32'h0);
        add(1, 1, 0, 0, 8'h66, 0, 0, 0, 0, 8'd2, 16'd0, 0, 0, 32'h0);
        add(1, 1, 0, 0, 8'h77, 0, 0, 0, 0, 8'd2, 16'd0, 0, 0, 32'h0);
        add(1, 1, 1, 0, 8'h3C, 0, 0, 0, 0, 8'd2, 16'd0, 0, 0, 32'h0);
        // Unknown K-character aborts the frame
        add(1, 1, 1, 0, 8'hFC, 0, 0, 0, 0, 8'd2, 16'd0, 0, 0, 32'h0);
        add(1, 1, 0, 0, 8'h88, 0, 0, 0, 1, 8'd2, 16'd0, 0, 0, 32'h0);
        add(1, 1, 1, 0, 8'h1C, 0, 0, 0, 1, 8'd2, 16'd0, 0, 0, 32'h0);
        add(1, 0, 0, 0, 8'h00, 0, 0, 0, 0, 8'd3, 16'd0, 0, 0, 32'h0);
        // SOF restart mid-record, K_IDLE and invalid bytes skipped
        add(1, 1, 1, 0, 8'hFC, 0, 0, 0, 0, 8'd3, 16'd0, 0, 0, 32'h0);
        add(1, 1, 0, 0, 8'h01, 0, 0, 0, 1, 8'd3, 16'd0, 0, 0, 32'h0);
        add(1, 1, 1, 0, 8'hFC, 0, 0, 0, 1, 8'd3, 16'd0, 0, 0, 32'h0);
        add(1, 1, 0, 0, 8'h02, 0, 0, 0, 1, 8'd4, 16'd0, 0, 0, 32'h0);
        add(1, 1, 1, 0, 8'h3C, 0, 0, 0, 1, 8'd4, 16'd0, 0, 0, 32'h0);
        add(1, 0, 1, 0, 8'hFC, 0, 0, 0, 1, 8'd4, 16'd0, 0, 0, 32'h0);
        add(1, 1, 0, 0, 8'h03, 0, 0, 0, 1, 8'd4, 16'd0, 0, 0, 32'h0);
        add(1, 1, 0, 0, 8'h04, 0, 0, 0, 1, 8'd4, 16'd0, 0, 1, 32'h05020304);
        add(1, 1, 1, 0, 8'hBC, 0, 0, 1, 1, 8'd4, 16'd0, 0, 0, 32'h0);
        add(1, 0, 0, 0, 8'h00, 0, 0, 0, 0, 8'd4, 16'd0, 0, 0, 32'h0);
        // SOF and EOF at record boundary are not errors
        add(1, 1, 1, 0, 8'hFC, 0, 0, 0, 0, 8'd4, 16'd0, 0, 0, 32'h0);
        add(1, 1, 1, 0, 8'hFC, 0, 0, 0, 1, 8'd4, 16'd0, 0, 0, 32'h0);
        add(1, 1, 1, 0, 8'hBC, 0, 0, 0, 1, 8'd4, 16'd0, 0, 0, 32'h0);
        add(1, 0, 0, 0, 8'h00, 0, 0, 0, 0, 8'd4, 16'd0, 0, 0, 32'h0);
        // FIFO full: first record held stable, second dropped
        add(1, 1, 1, 0, 8'hFC, 1, 0, 0, 0, 8'd4, 16'd0, 0, 0, 32'h0);
        add(1, 1, 0, 0, 8'hA1, 1, 0, 0, 1, 8'd4, 16'd0, 0, 0, 32'h0);
        add(1, 1, 0, 0, 8'hA2, 1, 0, 0, 1, 8'd4, 16'd0, 0, 0, 32'h0);
        add(1, 1, 0, 0, 8'hA3, 1, 0, 0, 1, 8'd4, 16'd0, 0, 1, 32'h05A1A2A3);
        add(1, 1, 0, 0, 8'hB1, 1, 0, 0, 1, 8'd4, 16'd0, 1, 0, 32'h05A1A2A3);
        add(1, 1, 0, 0, 8'hB2, 1, 0, 0, 1, 8'd4, 16'd0, 1, 0, 32'h05A1A2A3);
        add(1, 1, 0, 0, 8'hB3, 1, 0, 0, 1, 8'd4, 16'd0, 1, 0, 32'h05A1A2A3);
        add(1, 1, 1, 0, 8'hBC, 1, 0, 0, 1, 8'd4, 16'd1, 1, 0, 32'h05A1A2A3);
        add(1, 0, 0, 0, 8'h00, 1, 0, 0, 0, 8'd4, 16'd1, 1, 0, 32'h05A1A2A3);
        add(1, 0, 0, 0, 8'h00, 0, 1, 1, 0, 8'd4, 16'd1, 1, 0, 32'h05A1A2A3);
        add(1, 0, 0, 0, 8'h00, 0, 0, 0, 0, 8'd0, 16'd0, 0, 0, 32'h0);
        // New record loads in the same cycle the held one drains
        add(1, 1, 1, 0, 8'hFC, 1, 0, 0, 0, 8'd0, 16'd0, 0, 0, 32'h0);
        add(1, 1, 0, 0, 8'hC1, 1, 0, 0, 1, 8'd0, 16'd0, 0, 0, 32'h0);
        add(1, 1, 0, 0, 8'hC2, 1, 0, 0, 1, 8'd0, 16'd0, 0, 0, 32'h0);
        add(1, 1, 0, 0, 8'hC3, 1, 0, 0, 1, 8'd0, 16'd0, 0, 1, 32'h05C1C2C3);
        add(1, 1, 0, 0, 8'hD1, 1, 0, 0, 1, 8'd0, 16'd0, 0, 0, 32'h0);
        add(1, 1, 0, 0, 8'hD2, 1, 0, 0, 1, 8'd0, 16'd0, 0, 0, 32'h0);
        add(1, 1, 0, 0, 8'hD3, 0, 0, 1, 1, 8'd0, 16'd0, 0, 1, 32'h05D1D2D3);
        add(1, 1, 1, 0, 8'hBC, 0, 0, 1, 1, 8'd0, 16'd0, 0, 0, 32'h0);
        add(1, 0, 0, 0, 8'h00, 0, 0, 0, 0, 8'd0, 16'd0, 0, 0, 32'h0);
        // Reset with a pending word and a partial record
        add(1, 1, 1, 0, 8'hFC, 1, 0, 0, 0, 8'd0, 16'd0, 0, 0, 32'h0);
        add(1, 1, 0, 0, 8'hE1, 1, 0, 0, 1, 8'd0, 16'd0, 0, 0, 32'h0);
        add(1, 1, 0, 0, 8'hE2, 1, 0, 0, 1, 8'd0, 16'd0, 0, 0, 32'h0);
        add(1, 1, 0, 0, 8'hE3, 1, 0, 0, 1, 8'd0, 16'd0, 0, 0, 32'h0);
        add(1, 1, 0, 0, 8'hF1, 1, 0, 0, 1, 8'd0, 16'd0, 1, 0, 32'h05E1E2E3);
        add(1, 1, 0, 0, 8'hF2, 1, 0, 0, 1, 8'd0, 16'd0, 1, 0, 32'h05E1E2E3);
        add(0, 1, 0, 0, 8'hF3, 0, 0, 0, 1, 8'd0, 16'd0, 0, 0, 32'h0);
        add(0, 1, 1, 0, 8'hFC, 0, 0, 0, 0, 8'd0, 16'd0, 1, 0, 32'h0);
        add(1, 0, 0, 0, 8'h00, 0, 0, 0, 0, 8'd0, 16'd0, 1, 0, 32'h0);
        add(1, 1, 1, 0, 8'hFC, 0, 0, 0, 0, 8'd0, 16'd0, 0, 0, 32'h0);
        add(1, 1, 0, 0, 8'h12, 0, 0, 0, 1, 8'd0, 16'd0, 0, 0, 32'h0);
        add(1, 1, 0, 0, 8'h34, 0, 0, 0, 1, 8'd0, 16'd0, 0, 0, 32'h0);
        add(1, 1, 0, 0, 8'h56, 0, 0, 0, 1, 8'd0, 16'd0, 0, 1, 32'h05123456);
        add(1, 1, 1, 0, 8'hBC, 0, 0, 1, 1, 8'd0, 16'd0, 0, 0, 32'h0);
        add(1, 0, 0, 0, 8'h00, 0, 0, 0, 0, 8'd0, 16'd0, 0, 0, 32'h0);

        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < vecs.size(); i++)
            runVec(vecs[i], i);

        // Error counter saturation, then clear racing an error
        for (int i = 0; i < 300; i++)
            runVec(mk(1, 1, 0, 1, 8'h00, 0, 0, 0, 0, (i > 255) ? 8'hFF : 8'(i), 16'd0,
                      0, 0, 32'h0), 1000 + i);
        runVec(mk(1, 1, 0, 1, 8'h00, 0, 1, 0, 0, 8'hFF, 16'd0, 0, 0, 32'h0), 2000);
        runVec(mk(1, 0, 0, 0, 8'h00, 0, 0, 0, 0, 8'h00, 16'd0, 0, 0, 32'h0), 2001);

        compare("sb_leftover", 2002, sbq.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fei4_rx_record_packer.md
FEI4_RX_RECORD_PACKER -- requirements
Module: fei4_rx_record_packer

Interface
REQ-001 SHALL have parameter CHANNEL_ID, default 8'h00, meaning constant placed in word bits [31:24].
REQ-002 SHALL have parameter K_SOF, default 8'hFC, meaning start-of-frame K-character value.
REQ-003 SHALL have parameter K_EOF, default 8'hBC, meaning end-of-frame K-character value.
REQ-004 SHALL have parameter K_IDLE, default 8'h3C, meaning idle K-character value.
REQ-005 clk  input  1  single clock, all logic on rising edge.
REQ-006 reset  input  1  synchronous, active-low reset.
REQ-007 byte_in  input  8  decoded byte from 8b/10b decoder.
REQ-008 byte_valid  input  1  byte_in/is_k/dec_err valid this cycle.
REQ-009 is_k  input  1  byte_in is a K-character.
REQ-010 dec_err  input  1  decoder code/disparity error on this byte.
REQ-011 cnt_clear  input  1  synchronous clear of both counters.
REQ-012 fifo_full  input  1  downstream FIFO full flag (combinational, same cycle).
REQ-013 fifo_write  output  1  write strobe to downstream FIFO.
REQ-014 fifo_data  output  32  word {CHANNEL_ID, record[23:0]}.
REQ-015 frame_active  output  1  high while inside a frame.
REQ-016 lost_count  output  16  records dropped for lack of space, saturating.
REQ-017 err_count  output  8  framing/decoder errors, saturating.

Function
REQ-018 SHALL implement states IDLE and FRAME plus 2-bit byte counter (0..2) valid in FRAME.
REQ-019 IDLE: byte_valid & is_k & byte_in==K_SOF -> FRAME, counter 0; any other byte ignored, no count.
REQ-020 FRAME, data byte (is_k=0, dec_err=0): shift into record (first byte -> [23:16], second -> [15:8], third -> [7:0]); counter increments, wraps 2->0 on record completion.
REQ-021 Record completes on the cycle the third byte is accepted; completed record offered to 1-entry holding register.
REQ-022 Holding register empty (or emptying this cycle) -> load record; occupied and not emptying -> drop record, lost_count +1.
REQ-023 fifo_write = holding-register-valid & !fifo_full; fifo_data = holding register; register frees in same cycle fifo_write is high.
REQ-024 Latency: third byte accepted in cycle N -> fifo_write earliest in cycle N+1 with record on fifo_data.
REQ-025 fifo_data SHALL be stable while holding register valid and fifo_full high.
REQ-026 FRAME, K_EOF: -> IDLE; counter!=0 -> partial record discarded, err_count +1.
REQ-027 FRAME, K_SOF: partial discarded, counter 0, stay FRAME; err_count +1 only if counter!=0.
REQ-028 FRAME, K_IDLE: ignored, no state change.
REQ-029 FRAME, any other K-character: -> IDLE, partial discarded, err_count +1.
REQ-030 dec_err with byte_valid, any state: partial discarded, -> IDLE, err_count +1 (one count per byte); overrides is_k/byte_in decoding.
REQ-031 byte_valid low: no state, counter or record change.
REQ-032 Counters saturate at all-ones (16'hFFFF, 8'hFF); no wrap.
REQ-033 cnt_clear: both counters 0 next cycle; clear wins over simultaneous increment; no effect on data path.
REQ-034 frame_active = (state==FRAME), registered.

Reset
REQ-035 reset low at a clock edge: state IDLE, counter 0, holding register empty, fifo_write 0, fifo_data 0, frame_active 0, lost_count 0, err_count 0.
REQ-036 Reset mid-frame or with pending word: pending word and partial record discarded, not written, not counted.
REQ-037 Outputs SHALL hold reset values every cycle reset is low, regardless of byte_valid.

Verification
REQ-038 SOF, AB, CD, EF, EOF, fifo_full=0, CHANNEL_ID=8'h05 -> one fifo_write, fifo_data 32'h05ABCDEF, cycle after EF; err_count 0.
REQ-039 SOF, 6 data bytes, fifo_full held 1 throughout -> first record held stable, second dropped; lost_count 1; releasing full -> exactly one write of first record.
REQ-040 SOF, 2 data bytes, EOF -> no write, err_count 1, frame_active 0 after EOF.
REQ-041 Data byte with dec_err in FRAME -> IDLE, err_count +1; following data bytes without SOF ignored.
REQ-042 Drive 300 error events -> err_count saturates 8'hFF; cnt_clear together with error -> err_count 0.
REQ-043 Reset low after 2 bytes of a record with pending word -> no fifo_write, all outputs 0; after release, new SOF+3 bytes -> exactly one correct word.
